// File: rtl/l2_tag_ctrl.sv
// l2_tag_ctrl: clears the 16x24 L2 tag SRAM after reset, then arbitrates its single port between lookups and updates
module l2_tag_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 6,
   parameter int SET_W    = 4,
   parameter int TAG_W    = ADDR_W - SET_W - OFFSET_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               lkp_valid,
   output logic               lkp_ready,
   input  logic [ADDR_W-1:0]  lkp_addr,
   output logic               lkp_resp_valid,
   output logic               lkp_hit,
   output logic               lkp_dirty,
   output logic [TAG_W-1:0]   lkp_tag,
   input  logic               upd_valid,
   output logic               upd_ready,
   input  logic [SET_W-1:0]   upd_set,
   input  logic [TAG_W+1:0]   upd_word,
   output logic               init_done,
   output logic               tag_csb0,
   output logic               tag_web0,
   output logic [SET_W-1:0]   tag_addr0,
   output logic [TAG_W+1:0]   tag_din0,
   input  logic [TAG_W+1:0]   tag_dout0
);
   typedef enum logic {INIT, RUN} state_t;
   state_t           state_q;
   logic [SET_W-1:0] cnt_q;
   logic             prio_upd_q;
   logic             pend_q;
   logic [TAG_W-1:0] req_tag_q;
   logic             run, gnt_lkp, gnt_upd, unused_ok;
   logic [SET_W-1:0] lkp_set;
   logic [TAG_W-1:0] lkp_tg;
   assign lkp_set   = lkp_addr[OFFSET_W+SET_W-1:OFFSET_W];
   assign lkp_tg    = lkp_addr[ADDR_W-1:OFFSET_W+SET_W];
   assign unused_ok = ^lkp_addr[OFFSET_W-1:0];
   assign run       = state_q == RUN;
   assign init_done = run;
   // readies depend only on valids and prio, so a losing requester simply holds valid
   assign upd_ready = run & (~lkp_valid | prio_upd_q);
   assign lkp_ready = run & (~upd_valid | ~prio_upd_q);
   assign gnt_lkp   = lkp_valid & lkp_ready;
   assign gnt_upd   = upd_valid & upd_ready;
   always_comb begin
      tag_csb0  = ~(~run | gnt_lkp | gnt_upd);
      tag_web0  = ~(~run | gnt_upd);
      tag_addr0 = ~run ? cnt_q : gnt_upd ? upd_set : lkp_set;
      tag_din0  = gnt_upd ? upd_word : '0;
   end
   // read data arrives the cycle after the grant, compared against the captured tag
   assign lkp_resp_valid = pend_q;
   assign lkp_hit        = pend_q & tag_dout0[TAG_W+1] & (tag_dout0[TAG_W-1:0] == req_tag_q);
   assign lkp_dirty      = pend_q & tag_dout0[TAG_W];
   assign lkp_tag        = pend_q ? tag_dout0[TAG_W-1:0] : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         prio_upd_q <= 1'b1;
         pend_q     <= 1'b0;
         req_tag_q  <= '0;
      end else begin
         if (!run) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) state_q <= RUN;
         end
         if (run && lkp_valid && upd_valid) prio_upd_q <= ~prio_upd_q;
         pend_q <= gnt_lkp;
         if (gnt_lkp) req_tag_q <= lkp_tg;
      end
   end
endmodule

// File: tb/tb_l2_tag_ctrl.sv
// tb_l2_tag_ctrl: directed checks of init clearing, arbitration, lookup pipeline and ordering against an SRAM model
module tb_l2_tag_ctrl;
   logic        clk = 0, rst = 1;
   logic        lkp_valid = 0, upd_valid = 0;
   logic [31:0] lkp_addr = '0;
   logic [3:0]  upd_set = '0;
   logic [23:0] upd_word = '0;
   logic        lkp_ready, lkp_resp_valid, lkp_hit, lkp_dirty, upd_ready, init_done;
   logic [21:0] lkp_tag;
   logic        tag_csb0, tag_web0;
   logic [3:0]  tag_addr0;
   logic [23:0] tag_din0, tag_dout0;
   int          npass = 0, ntot = 0;
   logic [23:0] mem [16];
   logic        csb_r = 1, web_r = 1;
   logic [3:0]  a_r = '0;
   logic [23:0] d_r = '0;

   l2_tag_ctrl dut (
      .clk(clk), .rst(rst), .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr),
      .lkp_resp_valid(lkp_resp_valid), .lkp_hit(lkp_hit), .lkp_dirty(lkp_dirty), .lkp_tag(lkp_tag),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_set(upd_set), .upd_word(upd_word),
      .init_done(init_done), .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0),
      .tag_din0(tag_din0), .tag_dout0(tag_dout0)
   );

   always #5 clk = ~clk;

   // macro model: control registered at one edge, write committed at the next, read from registered address
   initial for (int i = 0; i < 16; i++) mem[i] = 24'hA5A5A5;
   always @(posedge clk) begin
      if (!csb_r && !web_r) mem[a_r] <= d_r;
      csb_r <= tag_csb0;
      web_r <= tag_web0;
      a_r   <= tag_addr0;
      d_r   <= tag_din0;
   end
   assign tag_dout0 = mem[a_r];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_resp(input string tag, input logic [23:0] exp);
      #1;
      chk(tag, {7'd0, lkp_resp_valid, lkp_hit, lkp_dirty, lkp_tag}, {7'd0, 1'b1, exp[23:22], exp[21:0]});
   endtask

   initial begin
      lkp_valid = 1; upd_valid = 1;
      tick(); tick();
      #1;
      chk("reset_outputs", {lkp_resp_valid, lkp_hit, lkp_dirty, lkp_tag, init_done, lkp_ready, upd_ready}, '0);
      rst = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk($sformatf("init_wr%0d", i), {tag_csb0, tag_web0, tag_addr0, tag_din0, init_done, lkp_ready, upd_ready},
             {2'b00, 4'(i), 24'h0, 3'b000});
         tick();
      end
      lkp_valid = 0; upd_valid = 0;
      #1;
      chk("init_done_rise", {31'd0, init_done}, 32'd1);
      // first lookup: set 1, tag 4, cleared entry
      lkp_valid = 1; lkp_addr = 32'h0000_1040;
      #1;
      chk("lkp_grant", {lkp_ready, tag_csb0, tag_web0, tag_addr0}, {3'b101, 4'd1});
      tick();
      lkp_valid = 0;
      chk_resp("lkp_cleared", {2'b00, 22'h0});
      upd_valid = 1; upd_set = 4'd1; upd_word = 24'h800004;
      #1;
      chk("upd_grant", {upd_ready, tag_csb0, tag_web0, tag_addr0, tag_din0}, {3'b100, 4'd1, 24'h800004});
      tick();
      upd_valid = 0;
      lkp_valid = 1; lkp_addr = 32'h0000_1040;
      tick();
      lkp_addr = 32'h0000_2040;
      chk_resp("lkp_hit_after_upd", {2'b10, 22'h4});
      tick();
      lkp_valid = 0;
      chk_resp("lkp_miss_other_tag", {2'b00, 22'h4});
      tick();
      // contention: prio starts at update, then alternates
      for (int k = 0; k < 4; k++) begin
         upd_valid = 1; upd_set = 4'd5; upd_word = 24'h0;
         lkp_valid = 1; lkp_addr = 32'h0000_0080;
         #1;
         chk($sformatf("arb%0d", k), {29'd0, upd_ready, lkp_ready, lkp_resp_valid},
             {29'd0, k % 2 == 0, k % 2 == 1, k == 2});
         tick();
      end
      upd_valid = 0; lkp_valid = 0;
      #1;
      chk("arb_last_resp", {31'd0, lkp_resp_valid}, 32'd1);
      tick();
      // back-to-back lookups over all sets; only set 1 holds a nonzero tag
      for (int s = 0; s <= 16; s++) begin
         lkp_valid = s < 16;
         lkp_addr = 32'(s % 16) << 6;
         #1;
         if (s > 0)
            chk($sformatf("b2b_resp%0d", s - 1), {lkp_resp_valid, lkp_hit, lkp_tag}, {1'b1, 1'b0, (s - 1 == 1) ? 22'h4 : 22'h0});
         tick();
      end
      lkp_valid = 0;
      upd_valid = 1; upd_set = 4'd15; upd_word = 24'hFFFFFF;
      tick();
      upd_valid = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("idle_csb%0d", i), {31'd0, tag_csb0}, 32'd1);
         tick();
      end
      lkp_valid = 1; lkp_addr = 32'hFFFF_FFC0;
      tick();
      lkp_valid = 0;
      upd_valid = 1; upd_set = 4'd15; upd_word = 24'h0;
      chk_resp("dirty_hit_before_upd", {2'b11, 22'h3FFFFF});
      tick();
      upd_valid = 0; lkp_valid = 1;
      tick();
      lkp_valid = 0;
      chk_resp("after_clear_upd", {2'b00, 22'h0});
      tick();
      // reset in the middle of INIT
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 6; i++) tick();
      #1;
      chk("mid_init_addr6", {28'd0, tag_addr0}, 32'd6);
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk($sformatf("reinit_wr%0d", i), {tag_csb0, tag_web0, tag_addr0, init_done}, {2'b00, 4'(i), 1'b0});
         tick();
      end
      #1;
      chk("reinit_done", {31'd0, init_done}, 32'd1);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
